mem_arbiter: RTL and testbench

Shares one single-port synchronous block RAM between the core's instruction-fetch port and its load/store port. It sits between the `mips` core and a unified instruction/data RAM and replaces the separate `inst_ram_ena`/`data_ram_ena` paths. It grants at most one access per cycle, returns read data one cycle later, and holds each port's last read word. It asserts `stall` whenever a presented request is not granted.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 74 +++++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and default widths for the unified instruction/data RAM
// arbiter (mem_arbiter) and its grant picker (mem_arb_pick).
//   port_e         : which port owns a RAM access / pending read response
//   MEM_ARB_DW     : default data width
//   MEM_ARB_RAM_AW : default RAM word-address width
//   DCNT_W         : width of the data-burst counter (priority mode)
// Optional macro MEM_ARB_RR_EN (used by the including files) selects
// round-robin arbitration instead of data priority.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_I    = 2'd1,
    PORT_D    = 2'd2
  } port_e;

  localparam int MEM_ARB_DW     = 32;
  localparam int MEM_ARB_RAM_AW = 10;
  localparam int DCNT_W         = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational grant picker for mem_arbiter.
// Ports:
//   i_req, d_req : request lines (already qualified by reset)
//   d_misalign   : data address is not word aligned
//   dcnt         : consecutive data grants while fetch waits (priority mode)
//   rr_ptr       : port preferred on contention (MEM_ARB_RR_EN build)
//   i_gnt, d_gnt : grants; both may be set only when the data access is a
//                  misaligned reject that does not use the RAM
//   d_err        : misaligned data reject
//   ram_sel      : which port drives the RAM this cycle
// Macro: MEM_ARB_RR_EN selects round-robin instead of data priority.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int D_BURST_MAX = 4
) (
  input  logic              i_req,
  input  logic              d_req,
  input  logic              d_misalign,
`ifdef MEM_ARB_RR_EN
  input  port_e             rr_ptr,
`else
  input  logic [DCNT_W-1:0] dcnt,
`endif
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              d_err,
  output port_e             ram_sel
);

  logic fetch_wins;

`ifndef MEM_ARB_RR_EN
  localparam logic [DCNT_W-1:0] BURST_LIMIT = DCNT_W'(D_BURST_MAX);
`endif

  always_comb begin
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    d_err      = 1'b0;
    ram_sel    = PORT_NONE;
`ifdef MEM_ARB_RR_EN
    fetch_wins = (rr_ptr == PORT_I);
`else
    // Fetch only overtakes data once data has had its burst allowance.
    fetch_wins = (dcnt >= BURST_LIMIT);
`endif

    if (d_req && d_misalign) begin
      // A misaligned access is rejected without touching the RAM, so the
      // fetch port can use the RAM in the very same cycle.
      d_gnt = 1'b1;
      d_err = 1'b1;
      i_gnt = i_req;
    end else if (d_req && i_req) begin
      if (fetch_wins) begin
        i_gnt = 1'b1;
      end else begin
        d_gnt = 1'b1;
      end
    end else begin
      i_gnt = i_req;
      d_gnt = d_req;
    end

    if (i_gnt) begin
      ram_sel = PORT_I;
    end else if (d_gnt && !d_err) begin
      ram_sel = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the load/store port. One access per cycle, read data one cycle after
// the grant, last read word held per port.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   i_req/i_addr        : fetch request and byte address
//   i_gnt/i_rvalid/i_rdata : fetch grant, response valid, response/held data
//   d_req/d_we/d_addr/d_wdata : data request, store flag, address, store data
//   d_gnt/d_rvalid/d_rdata/d_err : data grant, load valid, load/held data,
//                         misaligned reject pulse
//   stall               : a presented request was not granted
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : RAM interface
// Macro: MEM_ARB_RR_EN selects round-robin arbitration; default build uses
// data priority with a fetch starvation limit of D_BURST_MAX.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_AW      = MEM_ARB_RAM_AW,
  parameter int DW          = MEM_ARB_DW,
  parameter int D_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              d_err,
  output logic              stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  // Requests are masked while reset is held so every output reads 0 then.
  logic  i_req_v;
  logic  d_req_v;
  logic  d_misalign;
  port_e ram_sel;

  port_e         rd_port_q, rd_port_d;
  logic [DW-1:0] i_hold_q, i_hold_d;
  logic [DW-1:0] d_hold_q, d_hold_d;

  // Address bits outside the word index are intentionally dropped.
  logic unused_addr_bits;

  assign i_req_v    = i_req & rst;
  assign d_req_v    = d_req & rst;
  assign d_misalign = |d_addr[1:0];
  assign unused_addr_bits = ^{i_addr[31:RAM_AW+2], i_addr[1:0], d_addr[31:RAM_AW+2]};

`ifdef MEM_ARB_RR_EN
  port_e rr_ptr_q, rr_ptr_d;
`else
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
`endif

  mem_arb_pick #(
    .D_BURST_MAX (D_BURST_MAX)
  ) u_pick (
    .i_req      (i_req_v),
    .d_req      (d_req_v),
    .d_misalign (d_misalign),
`ifdef MEM_ARB_RR_EN
    .rr_ptr     (rr_ptr_q),
`else
    .dcnt       (dcnt_q),
`endif
    .i_gnt      (i_gnt),
    .d_gnt      (d_gnt),
    .d_err      (d_err),
    .ram_sel    (ram_sel)
  );

  assign stall = (i_req_v & ~i_gnt) | (d_req_v & ~d_gnt);

  // RAM drive follows the grant in the same cycle; idle cycles drive 0.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    rd_port_d = PORT_NONE;
    case (ram_sel)
      PORT_I: begin
        ram_en    = 1'b1;
        ram_addr  = i_addr[RAM_AW+1:2];
        rd_port_d = PORT_I;
      end
      PORT_D: begin
        ram_en    = 1'b1;
        ram_we    = d_we;
        ram_addr  = d_addr[RAM_AW+1:2];
        ram_wdata = d_wdata;
        rd_port_d = d_we ? PORT_NONE : PORT_D;
      end
      default: ;
    endcase
  end

  // Response path: the RAM word is live in the cycle after the read and is
  // then kept in the hold register of the port that asked for it.
  always_comb begin
    i_rvalid = (rd_port_q == PORT_I);
    d_rvalid = (rd_port_q == PORT_D);
    i_rdata  = i_rvalid ? ram_rdata : i_hold_q;
    d_rdata  = d_rvalid ? ram_rdata : d_hold_q;
    i_hold_d = i_rdata;
    d_hold_d = d_rdata;
  end

`ifdef MEM_ARB_RR_EN
  // Pointer names the port that wins the next contended cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (i_gnt) begin
      rr_ptr_d = PORT_D;
    end else if (d_gnt) begin
      rr_ptr_d = PORT_I;
    end
  end
`else
  // Counts data grants made while fetch is waiting; any fetch grant or a
  // cycle without a fetch request restarts the allowance.
  always_comb begin
    dcnt_d = dcnt_q;
    if (!i_req_v || i_gnt) begin
      dcnt_d = '0;
    end else if (d_gnt) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_port_q <= PORT_NONE;
      i_hold_q  <= '0;
      d_hold_q  <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q  <= PORT_I;
`else
      dcnt_q    <= '0;
`endif
    end else begin
      rd_port_q <= rd_port_d;
      i_hold_q  <= i_hold_d;
      d_hold_q  <= d_hold_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`else
      dcnt_q    <= dcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural single-port RAM.
// Stimulus pushes one expected-cycle record per clock plus expected read
// words into per-port queues; a monitor on the falling edge pops and
// compares. RAM word k is preloaded with 0xA000_0000 + k.
// Honours MEM_ARB_RR_EN for the contention pattern.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        stall;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic        ig, dg, de, en, we;
    logic [9:0]  addr;
    logic        st, iv, dv;
    logic [31:0] ih, dh;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  cyc_t        e_m;
  logic [31:0] pop_m;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc_n  = 0;
  logic        done   = 1'b0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .stall     (stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with registered read.
  initial begin
    ram_rdata = '0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'hA000_0000 + k;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL cycle %0d %s: got %h expected %h", cyc_n, nm, act, exp);
    end
  endtask

  // Monitor: compares one cycle record per falling edge.
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      e_m = cyc_q.pop_front();
      chk("i_gnt",    {31'd0, i_gnt},    {31'd0, e_m.ig});
      chk("d_gnt",    {31'd0, d_gnt},    {31'd0, e_m.dg});
      chk("d_err",    {31'd0, d_err},    {31'd0, e_m.de});
      chk("ram_en",   {31'd0, ram_en},   {31'd0, e_m.en});
      chk("ram_we",   {31'd0, ram_we},   {31'd0, e_m.we});
      if (e_m.en) chk("ram_addr", {22'd0, ram_addr}, {22'd0, e_m.addr});
      chk("stall",    {31'd0, stall},    {31'd0, e_m.st});
      chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, e_m.iv});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e_m.dv});
      if (i_rvalid) begin
        if (i_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL cycle %0d i_rdata: got unexpected response %h expected none", cyc_n, i_rdata);
        end else begin
          pop_m = i_q.pop_front();
          chk("i_rdata", i_rdata, pop_m);
        end
      end else begin
        chk("i_hold", i_rdata, e_m.ih);
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL cycle %0d d_rdata: got unexpected response %h expected none", cyc_n, d_rdata);
        end else begin
          pop_m = d_q.pop_front();
          chk("d_rdata", d_rdata, pop_m);
        end
      end else begin
        chk("d_hold", d_rdata, e_m.dh);
      end
      $display("cycle %0d rst=%b ig=%b dg=%b derr=%b en=%b we=%b addr=%0d stall=%b iv=%b ird=%h dv=%b drd=%h",
               cyc_n, rst, i_gnt, d_gnt, d_err, ram_en, ram_we, ram_addr, stall,
               i_rvalid, i_rdata, d_rvalid, d_rdata);
      cyc_n++;
    end else if (done) begin
      chk("i_queue_left", 32'(i_q.size()), 32'd0);
      chk("d_queue_left", 32'(d_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run expected finish before 100000");
    $fatal(1);
  end

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic cyc(input logic ig, input logic dg, input logic de, input logic en,
                     input logic we, input logic [9:0] a, input logic st,
                     input logic iv, input logic dv, input logic [31:0] ih,
                     input logic [31:0] dh);
    cyc_t c;
    c = '{ig: ig, dg: dg, de: de, en: en, we: we, addr: a, st: st,
          iv: iv, dv: dv, ih: ih, dh: dh};
    cyc_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   prev;
    logic seen_i, seen_d, gi;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // Reset state, then requests held during reset must be masked.
    cyc(0,0,0,0,0,0, 0,0,0, 0,0);
    set_in(1, 32'h8, 1, 0, 32'h44, 0);
    cyc(0,0,0,0,0,0, 0,0,0, 0,0);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,0, 0,0,0, 0,0);
    // Single fetch of word 2, response next cycle, then held.
    set_in(1, 32'h8, 0, 0, 0, 0);
    i_q.push_back(32'hA000_0002);
    cyc(1,0,0,1,0,10'd2, 0,0,0, 0,0);
    set_in(0, 0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,0, 0,1,0, 0,0);
    cyc(0,0,0,0,0,0, 0,0,0, 32'hA000_0002,0);
    cyc(0,0,0,0,0,0, 0,0,0, 32'hA000_0002,0);
    // Address wrap: byte 0x1004 lands on word 1.
    set_in(1, 32'h1004, 0, 0, 0, 0);
    i_q.push_back(32'hA000_0001);
    cyc(1,0,0,1,0,10'd1, 0,0,0, 32'hA000_0002,0);
    set_in(0, 0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,0, 0,1,0, 0,0);
    // Store then load of word 16.
    set_in(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    cyc(0,1,0,1,1,10'd16, 0,0,0, 32'hA000_0001,0);
    set_in(0, 0, 1, 0, 32'h40, 0);
    d_q.push_back(32'hDEAD_BEEF);
    cyc(0,1,0,1,0,10'd16, 0,0,0, 32'hA000_0001,0);
    set_in(0, 0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,0, 0,0,1, 32'hA000_0001,0);
    cyc(0,0,0,0,0,0, 0,0,0, 32'hA000_0001,32'hDEAD_BEEF);
    // Misaligned load alongside a fetch of word 3.
    set_in(1, 32'hC, 1, 0, 32'h41, 0);
    i_q.push_back(32'hA000_0003);
    cyc(1,1,1,1,0,10'd3, 0,0,0, 32'hA000_0001,32'hDEAD_BEEF);
    set_in(0, 0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,0, 0,1,0, 0,32'hDEAD_BEEF);
    // Contention: fetch word 8, load word 12, both held every cycle.
    set_in(1, 32'h20, 1, 0, 32'h30, 0);
    prev = 0; seen_i = 1'b0; seen_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
      gi = (k % 2 == 1);
`else
      gi = (k % 5 == 4);
`endif
      if (gi) i_q.push_back(32'hA000_0008);
      else    d_q.push_back(32'hA000_000C);
      cyc(gi, !gi, 0, 1, 0, gi ? 10'd8 : 10'd12, 1, prev == 1, prev == 2,
          seen_i ? 32'hA000_0008 : 32'hA000_0003,
          seen_d ? 32'hA000_000C : 32'hDEAD_BEEF);
      if (prev == 1) seen_i = 1'b1;
      if (prev == 2) seen_d = 1'b1;
      prev = gi ? 1 : 2;
    end
    set_in(0, 0, 0, 0, 0, 0);
    cyc(0,0,0,0,0,0, 0,1,0, 32'hA000_0008,32'hA000_000C);
    // Read granted, then reset in the following cycle: response discarded.
    set_in(1, 32'h14, 0, 0, 0, 0);
    cyc(1,0,0,1,0,10'd5, 0,0,0, 32'hA000_0008,32'hA000_000C);
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(0,0,0,0,0,0, 0,0,0, 0,0);
    rst = 1'b1;
    cyc(0,0,0,0,0,0, 0,0,0, 0,0);
    cyc(0,0,0,0,0,0, 0,0,0, 0,0);
    done = 1'b1;
  end

endmodule
